// File: rtl/rec_pkg.sv
// Shared definitions for the CAN receive buffer: default sizes, word type, pointer width.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rec_pkg;

    localparam int REC_BYTEW = 8;
    localparam int REC_DEPTH = 8;

    // One received word: {high byte, low byte} as written by the MAC.
    typedef logic [2*REC_BYTEW-1:0] rec_word_t;

    // Pointers carry one extra bit so that full and empty stay distinguishable.
    function automatic int rec_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rec_fifo_mem.sv
// Word storage for the receive buffer: DEPTH x WW register array.
// Latency: write lands on the next rising edge; read is combinational.
// Backpressure: none here; the caller only asserts we when a slot is free.
module rec_fifo_mem
    import rec_pkg::*;
#(
    parameter int DEPTH = REC_DEPTH,
    parameter int WW    = 2 * REC_BYTEW,
    parameter int AW    = $clog2(REC_DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [WW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [WW-1:0] rdata
);

    logic [WW-1:0] mem_q [DEPTH];
    logic [WW-1:0] mem_d [DEPTH];

    // Next memory image: one slot replaced on a write, contents otherwise held.
    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // Storage register; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rec_fifo.sv
// CAN receive buffer: MAC stages words per frame, commit exposes them, CPU pops in order.
// Latency: committed word visible on regout right after the committing edge (show-ahead).
// Backpressure: none to the MAC; words arriving while full are dropped and flagged via overrun.
module rec_fifo
    import rec_pkg::*;
#(
    parameter int DEPTH = REC_DEPTH,
    parameter int BYTEW = REC_BYTEW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       can,
    input  logic [BYTEW-1:0]           regin1,
    input  logic [BYTEW-1:0]           regin2,
    input  logic                       commit,
    input  logic                       abort,
    input  logic                       rd,
    input  logic                       clr_ovr,
    output logic [2*BYTEW-1:0]         regout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overrun
);

    localparam int PW = rec_ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam int WW = 2 * BYTEW;
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] cm_ptr_q, cm_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          bad_q,     bad_d;
    logic          overrun_q, overrun_d;

    logic [PW-1:0] committed;
    logic [PW-1:0] occupied;
    logic          is_empty;
    logic          is_full;
    logic          wr_en;
    logic          drop;
    logic          rd_en;
    logic [WW-1:0] head_word;

    // Occupancy is derived from pre-edge pointers only.
    assign committed = cm_ptr_q - rd_ptr_q;
    assign occupied  = wr_ptr_q - rd_ptr_q;
    assign is_empty  = (committed == '0);
    assign is_full   = (occupied == DEPTH_P);

    assign wr_en = can & ~is_full;
    assign drop  = can &  is_full;
    assign rd_en = rd  & ~is_empty;

    // Pointer, bad and overrun next-state; abort beats commit, a drop poisons the frame.
    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        cm_ptr_d  = cm_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        bad_d     = bad_q | drop;
        overrun_d = overrun_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        if (abort) begin
            wr_ptr_d = cm_ptr_q;
            bad_d    = 1'b0;
        end else if (commit) begin
            if (bad_q | drop) begin
                wr_ptr_d = cm_ptr_q;
            end else begin
                cm_ptr_d = wr_ptr_d;
            end
            bad_d = 1'b0;
        end

        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (drop) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset; memory is left untouched.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q  <= '0;
            cm_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            bad_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            cm_ptr_q  <= cm_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            bad_q     <= bad_d;
            overrun_q <= overrun_d;
        end
    end

    rec_fifo_mem #(
        .DEPTH (DEPTH),
        .WW    (WW),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata ({regin1, regin2}),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (head_word)
    );

    assign regout  = is_empty ? '0 : head_word;
    assign empty   = is_empty;
    assign full    = is_full;
    assign level   = LW'(committed);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_rec_fifo.sv
// Directed bench for rec_fifo at DEPTH=8, BYTEW=8.
// Latency: inputs change 1 time unit after each rising edge, outputs checked there too.
// Backpressure: exercises full, drop, overrun and abort paths.
module tb_rec_fifo;
    import rec_pkg::*;

    logic            clk;
    logic            rst;
    logic            can;
    logic [7:0]      regin1;
    logic [7:0]      regin2;
    logic            commit;
    logic            abort;
    logic            rd;
    logic            clr_ovr;
    rec_word_t       regout;
    logic            empty;
    logic            full;
    logic [3:0]      level;
    logic            overrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    rec_fifo #(.DEPTH(8), .BYTEW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .can     (can),
        .regin1  (regin1),
        .regin2  (regin2),
        .commit  (commit),
        .abort   (abort),
        .rd      (rd),
        .clr_ovr (clr_ovr),
        .regout  (regout),
        .empty   (empty),
        .full    (full),
        .level   (level),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle; outputs are then stable for checking and inputs may change.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        can     = 1'b0;
        regin1  = 8'h00;
        regin2  = 8'h00;
        commit  = 1'b0;
        abort   = 1'b0;
        rd      = 1'b0;
        clr_ovr = 1'b0;
    endtask

    // One MAC word, no frame control.
    task automatic put_word(input rec_word_t w);
        can    = 1'b1;
        regin1 = w[15:8];
        regin2 = w[7:0];
        tick();
        idle_inputs();
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic do_read();
        rd = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
        chk_cnt++;
        if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
        chk_cnt++;
        if (regout !== 16'h0000) $display("FAIL reset_regout: got %h want 0000", regout); else pass_cnt++;
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else pass_cnt++;
    endtask

    task automatic test_single_frame();
        put_word(16'h1122);
        put_word(16'h3344);
        chk_cnt++;
        if (level !== 4'd0) $display("FAIL staged_invisible_level: got %0d want 0", level); else pass_cnt++;
        chk_cnt++;
        if (regout !== 16'h0000) $display("FAIL staged_invisible_regout: got %h want 0000", regout); else pass_cnt++;
        do_commit();
        chk_cnt++;
        if (level !== 4'd2) $display("FAIL single_level: got %0d want 2", level); else pass_cnt++;
        chk_cnt++;
        if (regout !== 16'h1122) $display("FAIL single_head0: got %h want 1122", regout); else pass_cnt++;
        do_read();
        chk_cnt++;
        if (regout !== 16'h3344) $display("FAIL single_head1: got %h want 3344", regout); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd1) $display("FAIL single_level1: got %0d want 1", level); else pass_cnt++;
        do_read();
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL single_empty: got %b want 1", empty); else pass_cnt++;
        chk_cnt++;
        if (regout !== 16'h0000) $display("FAIL single_regout0: got %h want 0000", regout); else pass_cnt++;
    endtask

    task automatic test_abort();
        put_word(16'h0101);
        put_word(16'h0202);
        put_word(16'h0303);
        do_abort();
        chk_cnt++;
        if (level !== 4'd0) $display("FAIL abort_level: got %0d want 0", level); else pass_cnt++;
        chk_cnt++;
        if (full !== 1'b0) $display("FAIL abort_full: got %b want 0", full); else pass_cnt++;
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL abort_empty: got %b want 1", empty); else pass_cnt++;
        put_word(16'hAAAA);
        do_commit();
        chk_cnt++;
        if (regout !== 16'hAAAA) $display("FAIL abort_next_frame: got %h want aaaa", regout); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd1) $display("FAIL abort_next_level: got %0d want 1", level); else pass_cnt++;
        do_read();
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL abort_drain: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 6; i++) put_word(16'h0600 + 16'(i));
        do_commit();
        chk_cnt++;
        if (level !== 4'd6) $display("FAIL ovf_level6: got %0d want 6", level); else pass_cnt++;
        put_word(16'h0B01);
        chk_cnt++;
        if (full !== 1'b0) $display("FAIL ovf_not_full7: got %b want 0", full); else pass_cnt++;
        put_word(16'h0B02);
        chk_cnt++;
        if (full !== 1'b1) $display("FAIL ovf_full8: got %b want 1", full); else pass_cnt++;
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL ovf_no_overrun_yet: got %b want 0", overrun); else pass_cnt++;
        put_word(16'h0B03);
        chk_cnt++;
        if (overrun !== 1'b1) $display("FAIL ovf_overrun: got %b want 1", overrun); else pass_cnt++;
        do_commit();
        chk_cnt++;
        if (level !== 4'd6) $display("FAIL ovf_commit_dropped: got %0d want 6", level); else pass_cnt++;
        chk_cnt++;
        if (full !== 1'b0) $display("FAIL ovf_after_full: got %b want 0", full); else pass_cnt++;
        for (int i = 1; i <= 6; i++) begin
            chk_cnt++;
            if (regout !== 16'h0600 + 16'(i))
                $display("FAIL ovf_readout%0d: got %h want %h", i, regout, 16'h0600 + 16'(i));
            else pass_cnt++;
            do_read();
        end
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL ovf_drained: got %b want 1", empty); else pass_cnt++;
        chk_cnt++;
        if (overrun !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overrun); else pass_cnt++;
    endtask

    task automatic test_ovr_clear();
        clr_ovr = 1'b1;
        tick();
        idle_inputs();
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL clr_alone1: got %b want 0", overrun); else pass_cnt++;
        for (int i = 0; i < 8; i++) put_word(16'h0C00 + 16'(i));
        chk_cnt++;
        if (full !== 1'b1) $display("FAIL clr_fill_full: got %b want 1", full); else pass_cnt++;
        can     = 1'b1;
        regin1  = 8'hDE;
        regin2  = 8'hAD;
        clr_ovr = 1'b1;
        tick();
        idle_inputs();
        chk_cnt++;
        if (overrun !== 1'b1) $display("FAIL clr_set_wins: got %b want 1", overrun); else pass_cnt++;
        clr_ovr = 1'b1;
        tick();
        idle_inputs();
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL clr_alone2: got %b want 0", overrun); else pass_cnt++;
        do_abort();
        chk_cnt++;
        if (full !== 1'b0) $display("FAIL clr_abort_full: got %b want 0", full); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd0) $display("FAIL clr_abort_level: got %0d want 0", level); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        can    = 1'b1;
        regin1 = 8'hBE;
        regin2 = 8'hEF;
        commit = 1'b1;
        tick();
        idle_inputs();
        chk_cnt++;
        if (level !== 4'd1) $display("FAIL can_commit_level: got %0d want 1", level); else pass_cnt++;
        chk_cnt++;
        if (regout !== 16'hBEEF) $display("FAIL can_commit_head: got %h want beef", regout); else pass_cnt++;
        do_read();
        put_word(16'h1111);
        can    = 1'b1;
        regin1 = 8'h22;
        regin2 = 8'h22;
        commit = 1'b1;
        abort  = 1'b1;
        tick();
        idle_inputs();
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL abort_wins_empty: got %b want 1", empty); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd0) $display("FAIL abort_wins_level: got %0d want 0", level); else pass_cnt++;
        do_read();
        chk_cnt++;
        if (level !== 4'd0) $display("FAIL rd_empty_level: got %0d want 0", level); else pass_cnt++;
        put_word(16'h5A5A);
        do_commit();
        chk_cnt++;
        if (regout !== 16'h5A5A) $display("FAIL rd_empty_head: got %h want 5a5a", regout); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd1) $display("FAIL rd_empty_level1: got %0d want 1", level); else pass_cnt++;
        can    = 1'b1;
        regin1 = 8'h6B;
        regin2 = 8'h6B;
        commit = 1'b1;
        rd     = 1'b1;
        tick();
        idle_inputs();
        chk_cnt++;
        if (regout !== 16'h6B6B) $display("FAIL rd_can_commit_head: got %h want 6b6b", regout); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd1) $display("FAIL rd_can_commit_level: got %0d want 1", level); else pass_cnt++;
        do_read();
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL simul_drain: got %b want 1", empty); else pass_cnt++;
    endtask

    task automatic test_wrap();
        rec_word_t v;
        for (int i = 0; i < 20; i++) begin
            v      = 16'h1000 + 16'(i * 16'h0111);
            can    = 1'b1;
            regin1 = v[15:8];
            regin2 = v[7:0];
            commit = 1'b1;
            tick();
            idle_inputs();
            chk_cnt++;
            if (regout !== v) $display("FAIL wrap_head%0d: got %h want %h", i, regout, v); else pass_cnt++;
            do_read();
            chk_cnt++;
            if (empty !== 1'b1) $display("FAIL wrap_empty%0d: got %b want 1", i, empty); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) put_word(16'h0D00 + 16'(i));
        do_commit();
        put_word(16'h0E00);
        put_word(16'h0E01);
        chk_cnt++;
        if (level !== 4'd4) $display("FAIL mid_pre_level: got %0d want 4", level); else pass_cnt++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_cnt++;
        if (empty !== 1'b1) $display("FAIL mid_empty: got %b want 1", empty); else pass_cnt++;
        chk_cnt++;
        if (level !== 4'd0) $display("FAIL mid_level: got %0d want 0", level); else pass_cnt++;
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL mid_overrun: got %b want 0", overrun); else pass_cnt++;
        chk_cnt++;
        if (regout !== 16'h0000) $display("FAIL mid_regout: got %h want 0000", regout); else pass_cnt++;
        for (int i = 0; i < 9; i++) put_word(16'h0F00 + 16'(i));
        chk_cnt++;
        if (overrun !== 1'b1) $display("FAIL mid2_overrun_set: got %b want 1", overrun); else pass_cnt++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_cnt++;
        if (overrun !== 1'b0) $display("FAIL mid2_overrun: got %b want 0", overrun); else pass_cnt++;
        chk_cnt++;
        if (full !== 1'b0) $display("FAIL mid2_full: got %b want 0", full); else pass_cnt++;
        put_word(16'h7777);
        do_commit();
        chk_cnt++;
        if (level !== 4'd1) $display("FAIL mid2_fresh_level: got %0d want 1", level); else pass_cnt++;
        chk_cnt++;
        if (regout !== 16'h7777) $display("FAIL mid2_fresh_head: got %h want 7777", regout); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        test_reset();
        test_single_frame();
        test_abort();
        test_overflow();
        test_ovr_clear();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
